// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - mm:ss countdown timer with load/start/stop control
//
// Purpose: counts a loaded MM:SS preset down once per TICK_DIV clock cycles.
// FSM states: IDLE, RUN, PAUSE and EXPIRED. Every output is registered.
//
// Ports:
//   clk              sole clock; all state changes on the rising edge
//   reset            asynchronous active-low reset
//   load             one-cycle pulse: load the preset, clamping each field to 59
//   load_mm/load_ss  preset minutes/seconds
//   start            one-cycle pulse: start from IDLE or resume from PAUSE
//   stop             one-cycle pulse: pause a running count
//   MM/SS            remaining minutes/seconds
//   running          high while in RUN
//   done             one-cycle pulse on the edge the count reaches 00:00
//   expired          high while in EXPIRED
//
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to make the count reload
// MM:SS from the preset at 00:00 and stay in RUN, instead of expiring.

module countdown_timer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] MM,
  output logic [5:0] SS,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]    state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [5:0]    mm_n, ss_n;
  logic [5:0]    dec_mm, dec_ss;
  logic          tick, dec_zero, done_n;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // The preset copy is only needed when the count reloads itself; in the
  // default build load drives MM/SS directly and nothing reads it back.
  logic [5:0] pre_mm, pre_ss, pre_mm_n, pre_ss_n;
`endif

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  // The tick fires on the edge where the prescaler would wrap to 0, so the
  // first one lands TICK_DIV cycles after entering RUN with a cleared count.
  assign tick = (state == ST_RUN) && (presc == PRESC_MAX);

  // One-second decrement with borrow from minutes; saturates at 00:00.
  always_comb begin
    dec_mm = MM;
    dec_ss = SS;
    if (SS != 6'd0) begin
      dec_ss = SS - 6'd1;
    end else if (MM != 6'd0) begin
      dec_mm = MM - 6'd1;
      dec_ss = 6'd59;
    end
  end

  assign dec_zero = (dec_mm == 6'd0) && (dec_ss == 6'd0);

  always_comb begin
    state_n = state;
    presc_n = presc;
    mm_n    = MM;
    ss_n    = SS;
    done_n  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    pre_mm_n = pre_mm;
    pre_ss_n = pre_ss;
`endif
    if (load) begin
      mm_n    = clamp59(load_mm);
      ss_n    = clamp59(load_ss);
      presc_n = '0;
      state_n = ST_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      pre_mm_n = clamp59(load_mm);
      pre_ss_n = clamp59(load_ss);
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!stop && start && (MM != 6'd0 || SS != 6'd0)) begin
            presc_n = '0;
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          // A stop edge freezes the prescaler where it is, so a resume
          // finishes the partially elapsed second.
          if (stop) begin
            state_n = ST_PAUSE;
          end else if (tick) begin
            presc_n = '0;
            mm_n    = dec_mm;
            ss_n    = dec_ss;
            if (dec_zero) begin
              done_n  = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (pre_mm != 6'd0 || pre_ss != 6'd0) begin
                mm_n = pre_mm;
                ss_n = pre_ss;
              end else begin
                state_n = ST_EXPIRED;
              end
`else
              state_n = ST_EXPIRED;
`endif
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (!stop && start) begin
            state_n = ST_RUN;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      presc   <= '0;
      MM      <= 6'd0;
      SS      <= 6'd0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      pre_mm  <= 6'd0;
      pre_ss  <= 6'd0;
`endif
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      MM      <= mm_n;
      SS      <= ss_n;
      running <= (state_n == ST_RUN);
      done    <= done_n;
      expired <= (state_n == ST_EXPIRED);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      pre_mm  <= pre_mm_n;
      pre_ss  <= pre_ss_n;
`endif
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed checks of countdown_timer against a seconds-based model

module tb_countdown_timer;

  localparam int TD = 5;
  localparam int MI = 0, MR = 1, MP = 2, ME = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [5:0] load_mm = 6'd0, load_ss = 6'd0;
  logic [5:0] MM, SS;
  logic       running, done, expired;

  always #5 clk = ~clk;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .load(load), .load_mm(load_mm), .load_ss(load_ss),
    .start(start), .stop(stop), .MM(MM), .SS(SS), .running(running),
    .done(done), .expired(expired)
  );

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: remaining time kept as a plain seconds count, plus the number of
  // RUN cycles elapsed in the current second.
  int m_mode = MI, m_rem = 0, m_preset = 0, m_phase = 0;
  bit m_done = 1'b0;

  function automatic int clamp(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    int mo, re, ph;
    bit dn;
    if (!reset) begin
      m_mode <= MI; m_rem <= 0; m_preset <= 0; m_phase <= 0; m_done <= 1'b0;
    end else begin
      mo = m_mode; re = m_rem; ph = m_phase; dn = 1'b0;
      if (load) begin
        re = clamp(int'(load_mm)) * 60 + clamp(int'(load_ss));
        m_preset <= re;
        ph = 0;
        mo = MI;
      end else if (mo == MI) begin
        if (start && !stop && re != 0) begin mo = MR; ph = 0; end
      end else if (mo == MR) begin
        if (stop) mo = MP;
        else begin
          ph++;
          if (ph == TD) begin
            ph = 0;
            re--;
            if (re == 0) begin
              dn = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (m_preset != 0) re = m_preset;
              else mo = ME;
`else
              mo = ME;
`endif
            end
          end
        end
      end else if (mo == MP) begin
        if (start && !stop) mo = MR;
      end
      m_mode <= mo; m_rem <= re; m_phase <= ph; m_done <= dn;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_mm", int'(MM), m_rem / 60);
      check("cyc_ss", int'(SS), m_rem % 60);
      check("cyc_running", int'(running), int'(m_mode == MR));
      check("cyc_expired", int'(expired), int'(m_mode == ME));
      check("cyc_done", int'(done), int'(m_done));
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input int mm, input int ss);
    load = 1'b1; load_mm = 6'(mm); load_ss = 6'(ss);
    nxt();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    nxt();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    nxt();
    stop = 1'b0;
  endtask

  initial begin
    int r;
    nxt();
    cmp_en = 1'b1;
    nxt();
    check("rst_mm", int'(MM), 0);
    check("rst_ss", int'(SS), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    check("rst_expired", int'(expired), 0);
    reset = 1'b1;
    nxt();

    // Scenario 1: 00:03 counts 2, 1, 0 five cycles apart.
    do_load(0, 3);
    do_start();
    check("s1_running", int'(running), 1);
    repeat (TD) nxt();
    check("s1_ss2", int'(SS), 2);
    repeat (TD) nxt();
    check("s1_ss1", int'(SS), 1);
    repeat (TD) nxt();
    check("s1_done", int'(done), 1);
    check("s1_model_done", int'(m_done), 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("s1_reload_ss", int'(SS), 3);
    check("s1_running_after", int'(running), 1);
`else
    check("s1_ss0", int'(SS), 0);
    check("s1_expired", int'(expired), 1);
    check("s1_running_after", int'(running), 0);
`endif
    nxt();
    check("s1_done_one_cycle", int'(done), 0);

    // Scenario 2: 01:00 borrows into 00:59 on the first tick.
    do_load(1, 0);
    do_start();
    repeat (TD) nxt();
    check("s2_mm", int'(MM), 0);
    check("s2_ss", int'(SS), 59);
    check("s2_model_rem", m_rem, 59);

    // Scenario 3: pause holds the partial second; resume finishes it.
    do_load(0, 10);
    do_start();
    repeat (7) nxt();
    do_stop();
    check("s3_pause_ss", int'(SS), 9);
    check("s3_pause_running", int'(running), 0);
    repeat (4) nxt();
    check("s3_pause_hold", int'(SS), 9);
    do_start();
    repeat (2) nxt();
    check("s3_before_tick", int'(SS), 9);
    nxt();
    check("s3_tick_after_3", int'(SS), 8);
    do_stop();
    start = 1'b1; stop = 1'b1;
    nxt();
    start = 1'b0; stop = 1'b0;
    check("s3_stop_over_start", int'(running), 0);

    // Scenario 4: clamping and priorities.
    do_load(63, 60);
    check("s4_clamp_mm", int'(MM), 59);
    check("s4_clamp_ss", int'(SS), 59);
    check("s4_model_preset", m_preset, 3599);
    load = 1'b1; start = 1'b1; load_mm = 6'd0; load_ss = 6'd4;
    nxt();
    load = 1'b0; start = 1'b0;
    check("s4_load_over_start", int'(running), 0);
    check("s4_load_ss", int'(SS), 4);
    do_load(0, 0);
    do_start();
    check("s4_start_at_zero", int'(running), 0);

    // Scenario 5: reset mid-count acts without a clock edge.
    do_load(0, 5);
    do_start();
    repeat (3) nxt();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("s5_async_ss", int'(SS), 0);
    check("s5_async_running", int'(running), 0);
    check("s5_async_expired", int'(expired), 0);
    nxt();
    reset = 1'b1;
    do_start();
    check("s5_start_ignored", int'(running), 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Scenario 6: 00:02 reloads every two seconds while staying in RUN.
    do_load(0, 2);
    do_start();
    for (int k = 0; k < 3; k++) begin
      repeat (2 * TD - 1) nxt();
      check("s6_no_early_done", int'(done), 0);
      nxt();
      check("s6_done", int'(done), 1);
      check("s6_reload_ss", int'(SS), 2);
      check("s6_running", int'(running), 1);
    end
`endif

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      load = 1'b0; start = 1'b0; stop = 1'b0;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        reset = 1'b0;
        nxt();
        reset = 1'b1;
      end else begin
        load = ($urandom_range(0, 99) < 3);
        load_mm = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
        load_ss = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
        start = ($urandom_range(0, 99) < 8);
        stop  = ($urandom_range(0, 99) < 3);
        nxt();
      end
    end
    load = 1'b0; start = 1'b0; stop = 1'b0;
    nxt();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, clock cycles per one-second tick (legal range 2 to 2^26).
REQ-002 Port: clk, input, 1, sole clock, all state on rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 Port: load, input, 1, single-cycle pulse that loads the preset time.
REQ-005 Port: load_mm, input, 6, preset minutes.
REQ-006 Port: load_ss, input, 6, preset seconds.
REQ-007 Port: start, input, 1, single-cycle pulse that starts or resumes counting.
REQ-008 Port: stop, input, 1, single-cycle pulse that pauses counting.
REQ-009 Port: MM, output, 6, remaining minutes (registered).
REQ-010 Port: SS, output, 6, remaining seconds (registered).
REQ-011 Port: running, output, 1, high while in the RUN state.
REQ-012 Port: done, output, 1, one-cycle pulse on expiry.
REQ-013 Port: expired, output, 1, high while in the EXPIRED state.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, PAUSE and EXPIRED; all outputs SHALL be registered.
REQ-015 load SHALL win in any state: clamp each field to 59, store both values in a preset register, drive MM/SS from them, clear the prescaler and go to IDLE.
REQ-016 load SHALL take priority over start and stop in the same cycle; stop SHALL take priority over start.
REQ-017 start in IDLE with MM:SS != 00:00 SHALL clear the prescaler and enter RUN; running SHALL be 1 on the edge after start is sampled.
REQ-018 start when MM:SS == 00:00 SHALL be ignored.
REQ-019 stop in RUN SHALL enter PAUSE and hold MM/SS and the prescaler value.
REQ-020 start in PAUSE SHALL resume RUN without clearing the prescaler.
REQ-021 start in EXPIRED SHALL be ignored; stop in IDLE, PAUSE or EXPIRED SHALL be ignored.
REQ-022 In RUN the prescaler SHALL count 0 to TICK_DIV-1 and SHALL produce a tick when it wraps to 0.
REQ-023 The first tick SHALL occur TICK_DIV cycles after entry to RUN from IDLE.
REQ-024 On a tick: if SS>0, SS SHALL decrement; if SS==0 and MM>0, MM SHALL decrement and SS SHALL become 59.
REQ-025 A tick that produces 00:00 SHALL enter EXPIRED on the same edge, with done=1 for exactly that cycle and expired=1 from that edge.
REQ-026 MM and SS SHALL never underflow and SHALL never exceed 59.

Reset
REQ-027 When reset=0 the block SHALL asynchronously set state=IDLE, MM=0, SS=0, preset=00:00, prescaler=0, running=0, done=0 and expired=0.
REQ-028 Reset assertion in any state, including mid-count, SHALL abort the count immediately.
REQ-029 Reset release SHALL be synchronous to clk, and the first edge with reset=1 SHALL be a normal operating edge.

Configuration
REQ-030 The feature SHALL be controlled by the macro COUNTDOWN_AUTO_RELOAD_EN.
REQ-031 With COUNTDOWN_AUTO_RELOAD_EN defined, a tick reaching 00:00 SHALL pulse done, reload MM/SS from the preset, clear the prescaler and remain in RUN. EXPIRED SHALL be unreachable and expired SHALL stay 0. A preset of 00:00 SHALL still enter EXPIRED.
REQ-032 With COUNTDOWN_AUTO_RELOAD_EN undefined, the behaviour SHALL be as in REQ-025, and the preset register SHALL be used only for load.

Verification (TICK_DIV=5)
REQ-033 Scenario 1: load 00:03, start -> SS reads 2, 1, 0 at 5-cycle spacing; done pulses once with SS=0; expired=1; running=0.
REQ-034 Scenario 2: load 01:00, start, wait one tick -> MM=0, SS=59.
REQ-035 Scenario 3: load 00:10, start, stop after 7 cycles -> PAUSE at 00:09 with the prescaler held; after start, the next tick arrives 3 cycles later (SS=8).
REQ-036 Scenario 4: load_mm=63, load_ss=60 -> MM=59, SS=59; load with start in the same cycle -> IDLE; start with stop in the same cycle in PAUSE -> stays PAUSE; start at 00:00 -> stays IDLE.
REQ-037 Scenario 5: reset=0 asserted mid-RUN between clock edges -> all outputs 0 with no clock edge required; after release, start is ignored (00:00).
REQ-038 Scenario 6 (COUNTDOWN_AUTO_RELOAD_EN defined): load 00:02, start -> done pulses every 10 cycles, MM:SS returns to 00:02, and running stays 1.
